// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // One-hot vector with only bit idx set.
  function automatic req_vec_t onehot(input logic [REQ_IDX_W-1:0] idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set bit of
// mask, starting at ptr+1 and wrapping, so ptr itself has lowest priority.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [REQ_IDX_W-1:0] ptr,
  input  req_vec_t             mask,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 found
);

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    logic [REQ_IDX_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + REQ_IDX_W'(k);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner selection for a shared 4:1 mux with a
// bounded hold window per owner. Optional per-requester grant counters are
// built when ARB_GRANT_CNT_EN is defined.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [REQ_IDX_W-1:0]   sel,
  output logic                   busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t           state_q, state_d;
  req_vec_t             gnt_q, gnt_d;
  logic [REQ_IDX_W-1:0] sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [REQ_IDX_W-1:0] last_ptr_q, last_ptr_d;

  req_vec_t             pick_mask;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic                 pick_found;
  logic                 own_req;

  // In GRANT only the other requesters compete; the owner is excluded.
  assign pick_mask = (state_q == GRANT) ? (req & ~gnt_q) : req;

  rr_pick u_pick (
    .ptr   (last_ptr_q),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: grant from idle, keep/extend/hand over/release in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    hold_d     = hold_q;
    last_ptr_d = last_ptr_q;
    own_req    = |(req & gnt_q);
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          busy_d     = 1'b1;
          hold_d     = '0;
          last_ptr_d = pick_idx;
        end
      end
      GRANT: begin
        if (own_req && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end else if (pick_found) begin
          // Window expired or owner released with others waiting: no bubble.
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          hold_d     = '0;
          last_ptr_d = pick_idx;
        end else if (own_req) begin
          // Nobody else wants the mux: open a fresh window for the owner.
          hold_d = '0;
        end else begin
          // sel keeps its last value; consumers qualify it with busy.
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State register; reset leaves requester 0 as first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      hold_q     <= '0;
      last_ptr_q <= REQ_IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

`ifdef ARB_GRANT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A new ownership starts whenever the next grant differs from the current one.
  logic new_owner;
  assign new_owner = busy_d && (gnt_d != gnt_q);

  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      // Saturating count of ownership starts for requester gi.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q[gi] <= '0;
        end else if (new_owner && (sel_d == REQ_IDX_W'(gi)) && (cnt_q[gi] != CNT_MAX)) begin
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
        end
      end
      assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (default MAX_HOLD=8, CNT_W=8).
module tb_mux_rr_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
`ifdef ARB_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  int tests;
  int fails;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    check({tag, ".gnt"},  32'(gnt),  32'(eg));
    check({tag, ".sel"},  32'(sel),  32'(es));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    $display("[TB] %s req=%b gnt=%b sel=%0d busy=%b", tag, req, gnt, sel, busy);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    req     = 4'b1111;

    // Reset held with all requests active: nothing granted.
    step();
    step();
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    reset_n = 1'b1;

    // Full contention: 0,1,2,3,0 each for exactly 8 cycles, no bubbles.
    step();
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 8; c++) begin
        check_out($sformatf("rr_o%0d_c%0d", o % 4, c), 4'(1 << (o % 4)), 2'(o % 4), 1'b1);
        step();
      end
    end
    // Sampling point now sits at the first cycle of owner 1 again.
    check_out("rr_wrap", 4'b0010, 2'd1, 1'b1);

    // Everyone drops: idle, sel retains its last value.
    req = 4'b0000;
    step();
    check_out("all_drop", 4'b0000, 2'd1, 1'b0);

    // Lone requester 2 keeps the grant across hold-window restarts.
    req = 4'b0100;
    step();
    check_out("solo_first", 4'b0100, 2'd2, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step();
      check_out($sformatf("solo_c%0d", c), 4'b0100, 2'd2, 1'b1);
    end

    // Owner 2 releases while 1 waits: direct handover.
    req = 4'b0010;
    step();
    check_out("hand_to_1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1010;
    step();
    check_out("hold_1", 4'b0010, 2'd1, 1'b1);
    // Owner 1 drops with 3 pending.
    req = 4'b1000;
    step();
    check_out("drop_to_3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    step();
    check_out("idle_sel3", 4'b0000, 2'd3, 1'b0);

    // Grant 1, then assert reset mid-cycle: outputs clear before the next edge.
    req = 4'b0010;
    step();
    check_out("pre_async", 4'b0010, 2'd1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    reset_n = 1'b1;
    req     = 4'b1010;
    step();
    check_out("ptr_reset", 4'b0010, 2'd1, 1'b1);

`ifdef ARB_GRANT_CNT_EN
    // Two requesters alternating for 40 cycles: owner starts 0,1,0,1,0.
    req     = 4'b0000;
    reset_n = 1'b0;
    step();
    check("cnt_reset", grant_cnt, 32'd0);
    reset_n = 1'b1;
    req     = 4'b0011;
    for (int c = 0; c < 40; c++) step();
    check("cnt0", 32'(grant_cnt[7:0]),  32'd3);
    check("cnt1", 32'(grant_cnt[15:8]), 32'd2);
    check("cnt2", 32'(grant_cnt[23:16]), 32'd0);
    check("cnt3", 32'(grant_cnt[31:24]), 32'd0);
    $display("[TB] counters cnt0=%0d cnt1=%0d", grant_cnt[7:0], grant_cnt[15:8]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
